// File: rtl/control_defs.sv
// Shared control encodings for the multicycle core controller.
// Pure definitions: no logic, no latency.
// Not applicable: carries no flow control of its own.
package control_defs;

  // Controller states, one per multicycle step.
  typedef enum logic [3:0] {
    FETCH,
    DECODE,
    MEMADR,
    MEMREAD,
    MEMWB,
    MEMWRITE,
    EXECUTER,
    EXECUTEI,
    ALUWB,
    JAL,
    BEQ
  } fsm_state_e;

  // Opcode field values recognised by the decoder.
  localparam logic [6:0] OP_LW    = 7'b0000011;
  localparam logic [6:0] OP_SW    = 7'b0100011;
  localparam logic [6:0] OP_RTYPE = 7'b0110011;
  localparam logic [6:0] OP_ITYPE = 7'b0010011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_BEQ   = 7'b1100011;

  // ALU class handed to alu_control.
  typedef enum logic [1:0] {
    ALU_ADD   = 2'b00,
    ALU_SUB   = 2'b01,
    ALU_FUNCT = 2'b10
  } alu_sel_e;

  // ALU operand A select.
  typedef enum logic [1:0] {
    SRCA_PC    = 2'b00,
    SRCA_OLDPC = 2'b01,
    SRCA_RS1   = 2'b10
  } src_a_e;

  // ALU operand B select.
  typedef enum logic [1:0] {
    SRCB_RS2   = 2'b00,
    SRCB_IMM   = 2'b01,
    SRCB_FOUR  = 2'b10
  } src_b_e;

  // Result bus select.
  typedef enum logic [1:0] {
    RES_ALUOUT    = 2'b00,
    RES_MEMDATA   = 2'b01,
    RES_ALURESULT = 2'b10
  } result_e;

  // True for every opcode the decoder dispatches somewhere other than FETCH.
  function automatic logic is_legal_op(input logic [6:0] o);
    return (o == OP_LW) || (o == OP_SW) || (o == OP_RTYPE) ||
           (o == OP_ITYPE) || (o == OP_JAL) || (o == OP_BEQ);
  endfunction

endpackage

// File: rtl/main_fsm.sv
// Multicycle controller: sequences fetch/decode/execute steps and decodes datapath controls per state.
// Latency: lw 5, sw/R/I/jal 4, beq 3 cycles with mem_ready held high.
// Backpressure: FETCH, MEMREAD and MEMWRITE hold while mem_ready is low.
module main_fsm
  import control_defs::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] op,
  input  logic       zero,
  input  logic       mem_ready,
  output logic [1:0] alu_op,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] result_src,
  output logic       adr_src,
  output logic       ir_write,
  output logic       pc_write,
  output logic       mem_write,
  output logic       reg_write,
  output logic       instr_retired,
  output logic       illegal_instr
);

  fsm_state_e state, next_state;
  logic       run;

  // Unqualified per-state requests; run gates them onto the strobe outputs.
  logic ir_req, pc_update, branch, mem_req, reg_req, retire_req, illegal_req;

  // Run flag: low through reset and the first cycle after release, so no
  // strobe can fire while the surrounding logic is still coming out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) run <= 1'b0;
    else        run <= 1'b1;
  end

  // State register; reset lands in FETCH asynchronously, aborting any access.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= FETCH;
    else        state <= next_state;
  end

  // Next-state logic; the machine idles in place until run is set.
  always_comb begin
    next_state = state;
    if (run) begin
      case (state)
        FETCH:    if (mem_ready) next_state = DECODE;
        DECODE: begin
          case (op)
            OP_LW, OP_SW: next_state = MEMADR;
            OP_RTYPE:     next_state = EXECUTER;
            OP_ITYPE:     next_state = EXECUTEI;
            OP_JAL:       next_state = JAL;
            OP_BEQ:       next_state = BEQ;
            default:      next_state = FETCH;
          endcase
        end
        MEMADR:   next_state = (op == OP_SW) ? MEMWRITE : MEMREAD;
        MEMREAD:  if (mem_ready) next_state = MEMWB;
        MEMWB:    next_state = FETCH;
        MEMWRITE: if (mem_ready) next_state = FETCH;
        EXECUTER, EXECUTEI, JAL: next_state = ALUWB;
        ALUWB, BEQ: next_state = FETCH;
        default:  next_state = FETCH;
      endcase
    end
  end

  // Per-state output decode; everything not named for a state stays 0.
  always_comb begin
    alu_op      = ALU_ADD;
    alu_src_a   = SRCA_PC;
    alu_src_b   = SRCB_RS2;
    result_src  = RES_ALUOUT;
    adr_src     = 1'b0;
    ir_req      = 1'b0;
    pc_update   = 1'b0;
    branch      = 1'b0;
    mem_req     = 1'b0;
    reg_req     = 1'b0;
    retire_req  = 1'b0;
    illegal_req = 1'b0;
    case (state)
      FETCH: begin
        alu_src_b  = SRCB_FOUR;
        result_src = RES_ALURESULT;
        ir_req     = mem_ready;
        pc_update  = mem_ready;
      end
      DECODE: begin
        alu_src_a   = SRCA_OLDPC;
        alu_src_b   = SRCB_IMM;
        illegal_req = !is_legal_op(op);
      end
      MEMADR: begin
        alu_src_a = SRCA_RS1;
        alu_src_b = SRCB_IMM;
      end
      MEMREAD:  adr_src = 1'b1;
      MEMWB: begin
        result_src = RES_MEMDATA;
        reg_req    = 1'b1;
        retire_req = 1'b1;
      end
      MEMWRITE: begin
        adr_src    = 1'b1;
        mem_req    = 1'b1;
        retire_req = mem_ready;
      end
      EXECUTER: begin
        alu_src_a = SRCA_RS1;
        alu_op    = ALU_FUNCT;
      end
      EXECUTEI: begin
        alu_src_a = SRCA_RS1;
        alu_src_b = SRCB_IMM;
        alu_op    = ALU_FUNCT;
      end
      ALUWB: begin
        reg_req    = 1'b1;
        retire_req = 1'b1;
      end
      JAL: begin
        alu_src_a = SRCA_OLDPC;
        alu_src_b = SRCB_FOUR;
        pc_update = 1'b1;
      end
      BEQ: begin
        alu_src_a  = SRCA_RS1;
        alu_op     = ALU_SUB;
        branch     = 1'b1;
        retire_req = 1'b1;
      end
      default: ;
    endcase
  end

  assign ir_write      = run & ir_req;
  assign pc_write      = run & (pc_update | (branch & zero));
  assign mem_write     = run & mem_req;
  assign reg_write     = run & reg_req;
  assign instr_retired = run & retire_req;
  assign illegal_instr = run & illegal_req;

endmodule

// File: tb/tb_main_fsm.sv
// Bench for main_fsm: directed scenarios plus randomized instruction streams.
// Each instruction is expanded into its expected step sequence and every cycle's outputs are compared.
// Memory steps get random stall cycles; op and zero are scrambled where they must not matter.
module tb_main_fsm;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [6:0] op = 7'd0;
  logic       zero = 1'b0;
  logic       mem_ready = 1'b0;
  logic [1:0] alu_op, alu_src_a, alu_src_b, result_src;
  logic       adr_src, ir_write, pc_write, mem_write, reg_write;
  logic       instr_retired, illegal_instr;

  int tests = 0;
  int fails = 0;

  localparam logic [6:0] T_LW  = 7'b0000011;
  localparam logic [6:0] T_SW  = 7'b0100011;
  localparam logic [6:0] T_R   = 7'b0110011;
  localparam logic [6:0] T_I   = 7'b0010011;
  localparam logic [6:0] T_JAL = 7'b1101111;
  localparam logic [6:0] T_BEQ = 7'b1100011;

  // Expected output vector while reset is held: FETCH selects, no strobes.
  localparam logic [14:0] RESET_VEC = {2'b00, 2'b00, 2'b10, 2'b10, 1'b0, 6'b000000};

  typedef enum {PF, PD, PMA, PMR, PMWB, PMWR, PER, PEI, PAW, PJ, PB} ph_e;

  logic [6:0] legal_ops [6];

  main_fsm dut (
    .clk(clk), .rst_n(rst_n), .op(op), .zero(zero), .mem_ready(mem_ready),
    .alu_op(alu_op), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .result_src(result_src), .adr_src(adr_src), .ir_write(ir_write),
    .pc_write(pc_write), .mem_write(mem_write), .reg_write(reg_write),
    .instr_retired(instr_retired), .illegal_instr(illegal_instr)
  );

  always #5 clk = ~clk;

  logic [14:0] obs;
  assign obs = {alu_op, alu_src_a, alu_src_b, result_src, adr_src,
                ir_write, pc_write, mem_write, reg_write, instr_retired, illegal_instr};

  // Expected outputs for one step, straight from the per-step control table.
  function automatic logic [14:0] exp_vec(ph_e p, logic rdy, logic z, logic [6:0] opc);
    logic [1:0] alu, a, b, res;
    logic adr, irw, pcw, mw, rw, ret, ill;
    alu = 2'b00; a = 2'b00; b = 2'b00; res = 2'b00;
    adr = 0; irw = 0; pcw = 0; mw = 0; rw = 0; ret = 0; ill = 0;
    case (p)
      PF:   begin b = 2'b10; res = 2'b10; irw = rdy; pcw = rdy; end
      PD:   begin a = 2'b01; b = 2'b01;
                  ill = !(opc inside {T_LW, T_SW, T_R, T_I, T_JAL, T_BEQ}); end
      PMA:  begin a = 2'b10; b = 2'b01; end
      PMR:  begin adr = 1; end
      PMWB: begin res = 2'b01; rw = 1; ret = 1; end
      PMWR: begin adr = 1; mw = 1; ret = rdy; end
      PER:  begin a = 2'b10; alu = 2'b10; end
      PEI:  begin a = 2'b10; b = 2'b01; alu = 2'b10; end
      PAW:  begin rw = 1; ret = 1; end
      PJ:   begin a = 2'b01; b = 2'b10; pcw = 1; end
      PB:   begin a = 2'b10; alu = 2'b01; pcw = z; ret = 1; end
      default: ;
    endcase
    return {alu, a, b, res, adr, irw, pcw, mw, rw, ret, ill};
  endfunction

  task automatic check(string tag, logic [14:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s: observed %b expected %b", tag, obs, expv);
    end
  endtask

  // One clock cycle in step p: drive inputs on the falling edge, check just after.
  task automatic cyc(ph_e p, logic rdy, logic [6:0] opc, int zmode, string tag);
    logic z;
    @(negedge clk);
    mem_ready = rdy;
    op = (p == PD || p == PMA) ? opc : 7'($urandom);
    z = (zmode == 2) ? 1'($urandom) : zmode[0];
    zero = z;
    #1 check($sformatf("%s_%s", tag, p.name()), exp_vec(p, rdy, z, opc));
  endtask

  // Memory step: stall cycles with mem_ready low, then the completing cycle.
  task automatic mem_step(ph_e p, int stall, logic [6:0] opc, int zmode, string tag);
    for (int i = 0; i < stall; i++) cyc(p, 1'b0, opc, zmode, $sformatf("%s_stall%0d", tag, i));
    cyc(p, 1'b1, opc, zmode, tag);
  endtask

  // Whole instruction as a step list; the next instruction's FETCH check
  // confirms the return to FETCH.
  task automatic run_instr(logic [6:0] opc, int fstall, int mstall, int zmode, string tag);
    ph_e seq[$];
    case (opc)
      T_LW:    seq = '{PF, PD, PMA, PMR, PMWB};
      T_SW:    seq = '{PF, PD, PMA, PMWR};
      T_R:     seq = '{PF, PD, PER, PAW};
      T_I:     seq = '{PF, PD, PEI, PAW};
      T_JAL:   seq = '{PF, PD, PJ, PAW};
      T_BEQ:   seq = '{PF, PD, PB};
      default: seq = '{PF, PD};
    endcase
    foreach (seq[k]) begin
      if (seq[k] == PF)
        mem_step(PF, fstall, opc, zmode, tag);
      else if (seq[k] == PMR || seq[k] == PMWR)
        mem_step(seq[k], mstall, opc, zmode, tag);
      else
        cyc(seq[k], 1'($urandom), opc, zmode, tag);
    end
  endtask

  // Hold reset across a clock edge, then release with strobes still quiet.
  task automatic do_reset(string tag);
    @(negedge clk);
    rst_n = 1'b0; mem_ready = 1'b1; op = T_R;
    #1 check({tag, "_hold"}, RESET_VEC);
    @(negedge clk);
    #1 check({tag, "_hold_edge"}, RESET_VEC);
    @(negedge clk);
    rst_n = 1'b1;
    #1 check({tag, "_release"}, RESET_VEC);
  endtask

  initial begin
    legal_ops = '{T_LW, T_SW, T_R, T_I, T_JAL, T_BEQ};

    do_reset("por");

    run_instr(T_R, 0, 0, 2, "rtype");
    run_instr(T_LW, 0, 2, 2, "lw_memstall");
    run_instr(T_BEQ, 0, 0, 1, "beq_taken");
    run_instr(T_BEQ, 0, 0, 0, "beq_not");
    run_instr(7'b1111111, 0, 0, 2, "illegal");
    run_instr(T_R, 4, 0, 2, "fetch_stall");
    run_instr(T_SW, 0, 1, 2, "sw");
    run_instr(T_I, 1, 0, 2, "itype");
    run_instr(T_JAL, 0, 0, 2, "jal");

    // Abort a store mid-access: mem_write must drop as soon as reset asserts.
    cyc(PF, 1'b1, T_SW, 2, "abort");
    cyc(PD, 1'b1, T_SW, 2, "abort");
    cyc(PMA, 1'b1, T_SW, 2, "abort");
    cyc(PMWR, 1'b0, T_SW, 2, "abort");
    #2 rst_n = 1'b0;
    #1 check("abort_async", RESET_VEC);
    do_reset("abort_rst");
    run_instr(T_LW, 0, 0, 2, "after_abort");

    for (int n = 0; n < 40; n++) begin
      logic [6:0] ropc;
      int sel;
      sel = $urandom_range(0, 7);
      ropc = (sel < 6) ? legal_ops[sel] : 7'($urandom);
      run_instr(ropc, $urandom_range(0, 2), $urandom_range(0, 3), 2,
                $sformatf("rnd%0d", n));
    end
    run_instr(T_R, 0, 0, 2, "tail");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
